// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle MIPS controller FSM
// Sequences FETCH/DCD/EXE/MEM/WB and drives datapath enables and selects from IR and ALU flags.
module multi_cycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ins,
  input  logic        zero,
  input  logic        mem_rdy,
  output logic        pc_we,
  output logic        ir_we,
  output logic        rf_we,
  output logic        mem_we,
  output logic        mem_re,
  output logic [2:0]  alu_func,
  output logic        alu_imm,
  output logic        ext_sign,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wd_sel,
  output logic [1:0]  npc_sel,
  output logic [1:0]  ld_type,
  output logic [2:0]  state,
  output logic        ins_done
);

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    DCD   = 3'd1,
    EXE   = 3'd2,
    MEM   = 3'd3,
    WB    = 3'd4
  } state_t;

  state_t cur, nxt;

  logic [5:0] opcode, funct;
  logic       is_r, is_addu, is_subu, is_jr, is_ori, is_lui;
  logic       is_lw, is_lh, is_lb, is_sw, is_beq, is_j, is_jal;
  logic       is_load, is_alu, is_legal;
  logic [1:0] ld_kind;
  logic       unused_ins;

  assign opcode     = ins[31:26];
  assign funct      = ins[5:0];
  assign unused_ins = ^ins[25:6];

  assign is_r    = (opcode == 6'h00);
  assign is_addu = is_r && (funct == 6'h21);
  assign is_subu = is_r && (funct == 6'h23);
  assign is_jr   = is_r && (funct == 6'h08);
  assign is_ori  = (opcode == 6'h0D);
  assign is_lui  = (opcode == 6'h0F);
  assign is_lw   = (opcode == 6'h23);
  assign is_lh   = (opcode == 6'h21);
  assign is_lb   = (opcode == 6'h20);
  assign is_sw   = (opcode == 6'h2B);
  assign is_beq  = (opcode == 6'h04);
  assign is_j    = (opcode == 6'h02);
  assign is_jal  = (opcode == 6'h03);

  assign is_load  = is_lw | is_lh | is_lb;
  assign is_alu   = is_addu | is_subu | is_ori | is_lui;
  assign is_legal = is_alu | is_load | is_sw | is_beq | is_j | is_jal | is_jr;
  assign ld_kind  = is_lh ? 2'd1 : (is_lb ? 2'd2 : 2'd0);

  assign state = cur;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur <= FETCH;
    else        cur <= nxt;
  end

  // Outputs are decoded straight from state/IR; reset gates every output to 0.
  always_comb begin
    nxt      = FETCH;
    pc_we    = 1'b0;
    ir_we    = 1'b0;
    rf_we    = 1'b0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    alu_func = 3'd0;
    alu_imm  = 1'b0;
    ext_sign = 1'b0;
    reg_dst  = 2'd0;
    wd_sel   = 2'd0;
    npc_sel  = 2'd0;
    ld_type  = 2'd0;
    ins_done = 1'b0;
    if (reset) begin
      case (cur)
        FETCH: begin
          ir_we = 1'b1;
          pc_we = 1'b1;
          nxt   = DCD;
        end
        DCD: begin
          if (is_j || is_jal || is_jr || !is_legal) begin
            ins_done = 1'b1;
            nxt      = FETCH;
            if (is_j || is_jal) begin
              pc_we   = 1'b1;
              npc_sel = 2'd2;
            end
            if (is_jal) begin
              rf_we   = 1'b1;
              reg_dst = 2'd2;
              wd_sel  = 2'd2;
            end
            if (is_jr) begin
              pc_we   = 1'b1;
              npc_sel = 2'd3;
            end
          end else begin
            nxt = EXE;
          end
        end
        EXE: begin
          if      (is_subu) alu_func = 3'd1;
          else if (is_ori)  alu_func = 3'd2;
          else if (is_beq)  alu_func = 3'd3;
          else if (is_lui)  alu_func = 3'd5;
          alu_imm  = is_ori | is_lui | is_load | is_sw;
          ext_sign = !(is_ori || is_lui);
          if (is_beq) begin
            pc_we    = zero;
            npc_sel  = 2'd1;
            ins_done = 1'b1;
            nxt      = FETCH;
          end else if (is_alu) begin
            nxt = WB;
          end else begin
            nxt = MEM;
          end
        end
        MEM: begin
          if (is_load) begin
            mem_re  = 1'b1;
            ld_type = ld_kind;
          end
          if (is_sw) mem_we = 1'b1;
          if (!mem_rdy) begin
            nxt = MEM;
          end else if (is_sw) begin
            ins_done = 1'b1;
            nxt      = FETCH;
          end else begin
            nxt = WB;
          end
        end
        WB: begin
          rf_we    = 1'b1;
          ins_done = 1'b1;
          reg_dst  = is_r ? 2'd1 : 2'd0;
          wd_sel   = is_load ? 2'd1 : 2'd0;
          ld_type  = is_load ? ld_kind : 2'd0;
          nxt      = FETCH;
        end
        default: nxt = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb/tb_multi_cycle_ctrl.sv - self-checking bench for multi_cycle_ctrl
module tb_multi_cycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ins;
  logic        zero, mem_rdy;
  logic        pc_we, ir_we, rf_we, mem_we, mem_re;
  logic [2:0]  alu_func;
  logic        alu_imm, ext_sign;
  logic [1:0]  reg_dst, wd_sel, npc_sel, ld_type;
  logic [2:0]  state;
  logic        ins_done;

  always #5 clk = ~clk;

  multi_cycle_ctrl dut (
    .clk(clk), .reset(reset), .ins(ins), .zero(zero), .mem_rdy(mem_rdy),
    .pc_we(pc_we), .ir_we(ir_we), .rf_we(rf_we), .mem_we(mem_we), .mem_re(mem_re),
    .alu_func(alu_func), .alu_imm(alu_imm), .ext_sign(ext_sign),
    .reg_dst(reg_dst), .wd_sel(wd_sel), .npc_sel(npc_sel), .ld_type(ld_type),
    .state(state), .ins_done(ins_done)
  );

  typedef struct {
    logic        rst;
    logic [31:0] ins;
    logic        zero;
    logic        rdy;
    logic [2:0]  st;
    logic        pc_we, ir_we, rf_we, mem_we, mem_re;
    logic [2:0]  alu_func;
    logic        alu_imm, ext_sign;
    logic [1:0]  reg_dst, wd_sel, npc_sel, ld_type;
    logic        ins_done;
  } cyc_t;

  cyc_t plan_q[$];
  cyc_t exp_q[$];

  int n_pass = 0, n_total = 0;
  int cnt = 0, re_cnt = 0, we_cnt = 0;
  int last_len = 0, last_re = 0, last_we = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
  endtask

  function automatic cyc_t blank(input logic [2:0] st, input logic [31:0] i);
    cyc_t c;
    c.rst = 1'b1; c.ins = i; c.zero = 1'($urandom); c.rdy = 1'($urandom); c.st = st;
    c.pc_we = 0; c.ir_we = 0; c.rf_we = 0; c.mem_we = 0; c.mem_re = 0;
    c.alu_func = 0; c.alu_imm = 0; c.ext_sign = 0;
    c.reg_dst = 0; c.wd_sel = 0; c.npc_sel = 0; c.ld_type = 0; c.ins_done = 0;
    return c;
  endfunction

  function automatic cyc_t reset_cyc(input logic [31:0] i);
    cyc_t c;
    c = blank(3'd0, i);
    c.rst = 1'b0;
    c.rdy = 1'b0;
    return c;
  endfunction

  // Expected per-cycle schedule for one instruction, derived from its class.
  task automatic plan(input logic [31:0] i, input logic z, input int n);
    logic [5:0] op, fn;
    logic addu, subu, jr, ori, lui, lw, lh, lb, sw, beq, j, jal, ld, ill;
    logic [1:0] lt;
    cyc_t c;
    op = i[31:26]; fn = i[5:0];
    addu = (op == 0) && (fn == 6'h21);
    subu = (op == 0) && (fn == 6'h23);
    jr   = (op == 0) && (fn == 6'h08);
    ori = (op == 6'h0D); lui = (op == 6'h0F); lw = (op == 6'h23); lh = (op == 6'h21);
    lb  = (op == 6'h20); sw  = (op == 6'h2B); beq = (op == 6'h04); j = (op == 6'h02);
    jal = (op == 6'h03);
    ld  = lw | lh | lb;
    lt  = lh ? 2'd1 : (lb ? 2'd2 : 2'd0);
    ill = !(addu | subu | jr | ori | lui | ld | sw | beq | j | jal);

    c = blank(3'd0, $urandom);
    c.ir_we = 1; c.pc_we = 1;
    plan_q.push_back(c);

    c = blank(3'd1, i);
    if (j || jal || jr || ill) begin
      c.ins_done = 1;
      c.pc_we    = !ill;
      c.npc_sel  = jr ? 2'd3 : (ill ? 2'd0 : 2'd2);
      if (jal) begin c.rf_we = 1; c.reg_dst = 2; c.wd_sel = 2; end
      plan_q.push_back(c);
      return;
    end
    plan_q.push_back(c);

    c = blank(3'd2, i);
    c.alu_func = subu ? 3'd1 : ori ? 3'd2 : beq ? 3'd3 : lui ? 3'd5 : 3'd0;
    c.alu_imm  = ori | lui | ld | sw;
    c.ext_sign = !(ori | lui);
    if (beq) begin
      c.zero = z; c.pc_we = z; c.npc_sel = 1; c.ins_done = 1;
      plan_q.push_back(c);
      return;
    end
    plan_q.push_back(c);

    if (ld || sw) begin
      for (int k = 0; k <= n; k++) begin
        c = blank(3'd3, i);
        c.rdy = (k == n);
        if (ld) begin c.mem_re = 1; c.ld_type = lt; end
        else    c.mem_we = 1;
        if (sw && k == n) c.ins_done = 1;
        plan_q.push_back(c);
      end
      if (sw) return;
    end

    c = blank(3'd4, i);
    c.rf_we = 1; c.ins_done = 1;
    c.reg_dst = (op == 0) ? 2'd1 : 2'd0;
    c.wd_sel  = ld ? 2'd1 : 2'd0;
    c.ld_type = ld ? lt : 2'd0;
    plan_q.push_back(c);
  endtask

  task automatic run_plan();
    cyc_t c;
    while (plan_q.size() > 0) begin
      c = plan_q.pop_front();
      @(posedge clk);
      #1;
      reset = c.rst; ins = c.ins; zero = c.zero; mem_rdy = c.rdy;
      exp_q.push_back(c);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic run_one(input string name, input logic [31:0] i, input logic z, input int n,
                         input int want_len);
    plan(i, z, n);
    run_plan();
    check({name, " cycles"}, last_len, want_len);
  endtask

  always @(negedge clk) begin
    cyc_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("state",    state,    e.st);
      check("pc_we",    pc_we,    e.pc_we);
      check("ir_we",    ir_we,    e.ir_we);
      check("rf_we",    rf_we,    e.rf_we);
      check("mem_we",   mem_we,   e.mem_we);
      check("mem_re",   mem_re,   e.mem_re);
      check("alu_func", alu_func, e.alu_func);
      check("alu_imm",  alu_imm,  e.alu_imm);
      check("ext_sign", ext_sign, e.ext_sign);
      check("reg_dst",  reg_dst,  e.reg_dst);
      check("wd_sel",   wd_sel,   e.wd_sel);
      check("npc_sel",  npc_sel,  e.npc_sel);
      check("ld_type",  ld_type,  e.ld_type);
      check("ins_done", ins_done, e.ins_done);
      if (!reset) begin
        cnt = 0; re_cnt = 0; we_cnt = 0;
      end else begin
        cnt++;
        re_cnt += int'(mem_re);
        we_cnt += int'(mem_we);
        if (ins_done) begin
          last_len = cnt; last_re = re_cnt; last_we = we_cnt;
          cnt = 0; re_cnt = 0; we_cnt = 0;
        end
      end
    end
  end

  initial begin
    reset = 1'b0; ins = 32'h0; zero = 1'b0; mem_rdy = 1'b0;
    plan_q.push_back(reset_cyc(32'h0));
    plan_q.push_back(reset_cyc(32'h0));
    run_plan();

    run_one("addu", 32'h00221821, 1'b0, 0, 4);
    run_one("lh",   32'h84220004, 1'b0, 2, 7);
    check("lh mem_re cycles", last_re, 3);
    run_one("beq taken",     32'h10220003, 1'b1, 0, 3);
    run_one("beq not taken", 32'h10220003, 1'b0, 0, 3);
    run_one("jal",  32'h0C000010, 1'b0, 0, 2);
    run_one("jr",   32'h03E00008, 1'b0, 0, 2);
    run_one("illegal", 32'hFC000000, 1'b0, 0, 2);
    run_one("sw",   32'hAC220008, 1'b0, 0, 4);
    check("sw mem_we cycles", last_we, 1);
    run_one("sw stall", 32'hAC220008, 1'b0, 2, 6);
    check("sw stall mem_we cycles", last_we, 3);
    run_one("subu", 32'h00221823, 1'b0, 0, 4);
    run_one("ori",  32'h3422FFFF, 1'b0, 0, 4);
    run_one("lui",  32'h3C011234, 1'b0, 0, 4);
    run_one("lb",   32'h80220001, 1'b0, 1, 6);
    run_one("lw",   32'h8C220000, 1'b0, 0, 5);
    run_one("j",    32'h08000010, 1'b0, 0, 2);
    run_one("illegal funct", 32'h0022182A, 1'b0, 0, 2);

    // Abort a stalled lw in MEM: keep FETCH..MEM+1 stall cycle, then assert reset.
    plan(32'h8C220000, 1'b0, 5);
    repeat (5) void'(plan_q.pop_back());
    plan_q.push_back(reset_cyc(32'h8C220000));
    plan_q.push_back(reset_cyc(32'h8C220000));
    plan(32'h00221821, 1'b0, 0);
    run_plan();
    check("post-reset addu cycles", last_len, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Finite-state controller for the multi-cycle MIPS core. It sequences the shared datapath through fetch, decode, execute, memory and write-back states. The datapath is one ALU, one unified PC/NPC path, the register file and data memory, and the controller drives their enables and selects each cycle from the registered instruction (IR) and ALU flags. It supports the same instruction subset as the single-cycle core: addu, subu, ori, lui, lw, lh, lb, sw, beq, j, jal, jr.

## Interface
- No parameters.
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- ins  in  32  current IR contents, valid from the cycle after `ir_we`.
- zero  in  1  ALU equality flag, valid in EXE.
- mem_rdy  in  1  data-memory ready; the MEM access completes in a cycle with `mem_rdy`=1.
- pc_we  out  1  PC write enable.
- ir_we  out  1  IR write enable.
- rf_we  out  1  register-file write enable.
- mem_we  out  1  data-memory write enable.
- mem_re  out  1  data-memory read strobe.
- alu_func  out  3  ALU op: 0 add, 1 sub, 2 or, 3 compare, 5 lui.
- alu_imm  out  1  ALU B operand: 1 = extended immediate, 0 = rt.
- ext_sign  out  1  immediate extension: 1 = sign-extend, 0 = zero-extend.
- reg_dst  out  2  write register select: 0 = rt, 1 = rd, 2 = $31.
- wd_sel  out  2  write data select: 0 = ALU result register, 1 = load data, 2 = PC.
- npc_sel  out  2  next PC select: 0 = PC+4, 1 = branch target, 2 = jump target {PC[31:28],idx,2'b0}, 3 = rs.
- ld_type  out  2  load type: 0 = word, 1 = half (sign-extended), 2 = byte (sign-extended).
- state  out  3  current state, for debug and testbench use.
- ins_done  out  1  one-cycle pulse in the final cycle of each instruction.

## Operation
- States: FETCH=0, DCD=1, EXE=2, MEM=3, WB=4. The state register is the only sequential element.
- Decode: opcode=ins[31:26]; funct=ins[5:0] when opcode==0.
  - Recognised encodings: addu 0/21h, subu 0/23h, jr 0/08h; ori 0Dh, lui 0Fh, lw 23h, lh 21h, lb 20h, sw 2Bh, beq 04h, j 02h, jal 03h.
  - Any other encoding is illegal.
- FETCH:
  - Drive ir_we=1, pc_we=1, npc_sel=0.
  - Next state DCD.
- DCD:
  - j: pc_we=1, npc_sel=2.
  - jal: pc_we=1, npc_sel=2, rf_we=1, reg_dst=2, wd_sel=2. The PC value written is the already-incremented PC, i.e. PC+4.
  - jr: pc_we=1, npc_sel=3.
  - Illegal encoding: no enables asserted.
  - For the four cases above, next state is FETCH and ins_done=1.
  - All other instructions: next state EXE.
- EXE:
  - alu_func: addu, loads and sw → 0; subu → 1; ori → 2; beq → 3; lui → 5.
  - alu_imm=1 for ori, lui, loads and sw.
  - ext_sign=0 for ori and lui, 1 otherwise.
  - beq: pc_we=zero, npc_sel=1, ins_done=1; next state FETCH.
  - addu, subu, ori, lui: next state WB.
  - Loads and sw: next state MEM.
- MEM:
  - Loads: mem_re=1 and ld_type is driven.
  - sw: mem_we=1.
  - Stay in MEM while mem_rdy=0.
  - When mem_rdy=1: sw goes to FETCH with ins_done=1; loads go to WB.
- WB:
  - rf_we=1 and ins_done=1; next state FETCH.
  - R-type: reg_dst=1, wd_sel=0.
  - ori, lui: reg_dst=0, wd_sel=0.
  - Loads: reg_dst=0, wd_sel=1, ld_type held at its MEM value.
- Any output not listed for a state is 0.
- ins is ignored in FETCH.
- An unreachable state encoding (5–7) returns to FETCH on the next edge, with all outputs 0.

## Timing
- Outputs are combinational from state, ins and zero. Only pc_we in EXE depends on zero.
- Cycles per instruction:
  - j, jal, jr, illegal: 2.
  - beq: 3.
  - addu, subu, ori, lui: 4.
  - sw: 4 + N.
  - Loads: 5 + N.
  - N = number of MEM cycles with mem_rdy=0.
- During a MEM stall, mem_we and mem_re stay high and all other enables stay 0. With sw, mem_we is high for N+1 cycles and the store takes effect on the mem_rdy=1 cycle.
- Reset:
  - While reset=0: state=FETCH and all enables (pc_we, ir_we, rf_we, mem_we, mem_re) and ins_done are forced to 0.
  - All select outputs (alu_func, alu_imm, ext_sign, reg_dst, wd_sel, npc_sel, ld_type) are 0 while reset=0.
  - Assertion mid-instruction, including during a MEM stall, aborts the instruction immediately with no write.
  - After release, the first rising edge performs FETCH.
- mem_rdy is sampled only in MEM.

## Test plan
- Reset mid-MEM of `lw` with mem_rdy=0 → state=0 and all enables 0 immediately. After release, state sequence is 0→1 and ir_we=1 in the first cycle.
- `addu $3,$1,$2` (00221821h) → states 0,1,2,4. In WB: rf_we=1, reg_dst=1, wd_sel=0, ins_done=1. Total 4 cycles.
- `lh` (84220004h), mem_rdy low for 2 cycles → states 0,1,2,3,3,3,4. mem_re=1 for 3 cycles; WB has ld_type=1 and wd_sel=1. Total 7 cycles.
- `beq` (10220003h) → with zero=1: EXE has pc_we=1, npc_sel=1. With zero=0: EXE has pc_we=0. Both take 3 cycles.
- `jal` (0C000010h) → DCD has pc_we=1, npc_sel=2, rf_we=1, reg_dst=2, wd_sel=2, ins_done=1. `jr $31` (03E00008h) → DCD has npc_sel=3.
- Illegal FC000000h → 2 cycles, no enables in DCD, ins_done=1. `sw` with mem_rdy=1 → mem_we high for exactly 1 cycle, 4 cycles total.
